// File: rtl/mipi_hs_lane_ctrl_if.sv
// Pad-side and packet-side signals of the D-PHY HS lane controller.
// The master modport drives the lane pads; the slave modport is the controller.
interface mipi_hs_lane_ctrl_if #(
    parameter int unsigned LANES = 2
);
    logic [LANES-1:0]   lp_p;
    logic [LANES-1:0]   lp_n;
    logic [LANES-1:0]   hs_bit;
    logic               termination;
    logic [8*LANES-1:0] data;
    logic               data_valid;
    logic               hs_active;
    logic               sync_err;
    logic [2:0]         state_dbg;

    modport master (
        output lp_p, lp_n, hs_bit,
        input  termination, data, data_valid, hs_active, sync_err, state_dbg
    );

    modport slave (
        input  lp_p, lp_n, hs_bit,
        output termination, data, data_valid, hs_active, sync_err, state_dbg
    );
endinterface

// File: rtl/mipi_hs_lane_ctrl.sv
// D-PHY HS-entry controller: follows the LP request on lane 0, settles, finds
// the sync byte per lane and emits lane-merged byte words.
module mipi_hs_lane_ctrl #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned SYNC_TIMEOUT = 64,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic                bit_clk,
    input  logic                reset,
    mipi_hs_lane_ctrl_if.slave  bus
);
    localparam int unsigned CNT_MAX = (SETTLE_CYC > SYNC_TIMEOUT) ? SETTLE_CYC : SYNC_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LP01   = 3'd1,
        LP00   = 3'd2,
        SETTLE = 3'd3,
        SYNC   = 3'd4,
        RECV   = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [1:0]         lp;
    logic [CNT_W-1:0]   cnt;
    logic [LANES-1:0]   sync;
    logic [LANES-1:0]   pend;
    logic [7:0]         sr      [LANES];
    logic [7:0]         sr_nxt  [LANES];
    logic [7:0]         hold    [LANES];
    logic [2:0]         bitcnt  [LANES];
    logic [LANES-1:0]   hit_c;
    logic [LANES-1:0]   cap_c;
    logic               shifting;
    logic               timeout_c;
    logic               merge_c;
    logic               termination;
    logic [8*LANES-1:0] data;
    logic               data_valid;
    logic               hs_active;
    logic               sync_err;
    logic               unused_lp;

    // Only lane 0 carries the LP handshake; the other lanes' LP wires are ignored.
    assign lp        = {bus.lp_p[0], bus.lp_n[0]};
    assign unused_lp = ^{bus.lp_p, bus.lp_n};

    assign shifting  = (state == SYNC) || (state == RECV);
    assign timeout_c = (state == SYNC) && (cnt == CNT_W'(SYNC_TIMEOUT - 1)) && !(&sync);

    always_ff @(posedge bit_clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (lp == 2'b01) next_state = LP01;
            LP01: begin
                if (lp == 2'b00)      next_state = LP00;
                else if (lp[1])       next_state = IDLE;
            end
            LP00:    next_state = SETTLE;
            SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) next_state = SYNC;
            SYNC: begin
                if (&sync)            next_state = RECV;
                else if (timeout_c)   next_state = IDLE;
            end
            RECV:    if (lp == 2'b11) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shared settle/timeout counter restarts on every state change.
    always_ff @(posedge bit_clk) begin
        if (reset || (next_state != state))           cnt <= '0;
        else if ((state == SETTLE) || (state == SYNC)) cnt <= cnt + CNT_W'(1);
    end

    // Byte-boundary look-ahead: decisions use the value sr takes at this edge.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            sr_nxt[k] = {bus.hs_bit[k], sr[k][7:1]};
            hit_c[k]  = (state == SYNC) && !sync[k] && (sr_nxt[k] == SYNC_BYTE);
            cap_c[k]  = shifting && sync[k] && (bitcnt[k] == 3'd7);
        end
    end

    // A merge never fires on the edge that leaves for IDLE, so partial words are lost.
    assign merge_c = (&pend) && (next_state != IDLE);

    always_ff @(posedge bit_clk) begin
        if (reset) begin
            termination <= 1'b0;
            data        <= '0;
            data_valid  <= 1'b0;
            hs_active   <= 1'b0;
            sync_err    <= 1'b0;
            sync        <= '0;
            pend        <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                sr[k]     <= '0;
                hold[k]   <= '0;
                bitcnt[k] <= '0;
            end
        end else begin
            termination <= (state == LP00) || (state == SETTLE) || (state == SYNC) || (state == RECV);
            hs_active   <= (next_state == RECV);
            sync_err    <= timeout_c;
            data_valid  <= 1'b0;
            if (next_state == IDLE) begin
                sync <= '0;
                pend <= '0;
                for (int unsigned k = 0; k < LANES; k++) begin
                    sr[k]     <= '0;
                    bitcnt[k] <= '0;
                end
            end else begin
                if (merge_c) begin
                    data_valid <= 1'b1;
                    for (int unsigned k = 0; k < LANES; k++) data[8*k +: 8] <= hold[k];
                end
                for (int unsigned k = 0; k < LANES; k++) begin
                    if ((next_state == SYNC) && (state != SYNC)) sr[k] <= '0;
                    else if (shifting)                            sr[k] <= sr_nxt[k];

                    if (hit_c[k]) begin
                        sync[k]   <= 1'b1;
                        bitcnt[k] <= '0;
                    end else if (sync[k]) begin
                        bitcnt[k] <= bitcnt[k] + 3'd1;
                    end

                    // A byte landing on the merge edge is kept for the next word.
                    if (cap_c[k]) begin
                        hold[k] <= sr_nxt[k];
                        pend[k] <= 1'b1;
                    end else if (merge_c) begin
                        pend[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.termination = termination;
    assign bus.data        = data;
    assign bus.data_valid  = data_valid;
    assign bus.hs_active   = hs_active;
    assign bus.sync_err    = sync_err;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_mipi_hs_lane_ctrl.sv
// Directed bench for mipi_hs_lane_ctrl with two lanes: HS entry, skew,
// sync timeout, aborted request, mid-burst exit and reset recovery.
module tb_mipi_hs_lane_ctrl;
    localparam int unsigned LANES = 2;

    logic bit_clk = 1'b0;
    logic reset;
    always #5 bit_clk = ~bit_clk;

    mipi_hs_lane_ctrl_if #(.LANES(LANES)) bus ();

    mipi_hs_lane_ctrl #(
        .LANES(LANES), .SETTLE_CYC(16), .SYNC_TIMEOUT(64), .SYNC_BYTE(8'hB8)
    ) dut (
        .bit_clk(bit_clk),
        .reset(reset),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    int          v_count;
    int          v_idx  [4];
    logic [15:0] v_data [4];
    int          se_count;
    int          se_idx;
    logic        hs_last;
    logic        trm [80];
    logic [2:0]  st  [80];

    task automatic tick();
        @(posedge bit_clk);
        #1;
    endtask

    task automatic set_lp(input logic [1:0] v);
        bus.lp_p = {LANES{v[1]}};
        bus.lp_n = {LANES{v[0]}};
    endtask

    // Lane stream: B8,12,34 LSB first, lane 1 delayed; zeros elsewhere.
    function automatic logic lane_bit(input int lane, input int i, input int delay, input bit l1sync);
        logic [7:0] bytes [4];
        logic [7:0] b;
        int j;
        bytes[0] = 8'hB8; bytes[1] = 8'h12; bytes[2] = 8'h34; bytes[3] = 8'h00;
        j = (lane == 1) ? i - delay : i;
        if (j < 0 || j >= 32) return 1'b0;
        b = bytes[j / 8];
        if (lane == 1 && !l1sync) b = 8'h00;
        return b[j % 8];
    endfunction

    task automatic enter_hs(output logic t_lp01, output logic t_lp00, output logic t_settle,
                            output int n_settle, output bit ok);
        set_lp(2'b01); tick(); t_lp01 = bus.termination;
        set_lp(2'b00); tick(); t_lp00 = bus.termination;
        tick();                t_settle = bus.termination;
        ok = 1'b0;
        n_settle = -1;
        for (int n = 0; n < 40; n++) begin
            if (bus.state_dbg == 3'd4) begin
                ok = 1'b1;
                n_settle = n;
                break;
            end
            tick();
        end
    endtask

    task automatic feed(input int delay, input int nbits, input bit l1sync);
        v_count = 0; se_count = 0; se_idx = -1;
        for (int i = 0; i < nbits; i++) begin
            bus.hs_bit[0] = lane_bit(0, i, delay, 1'b1);
            bus.hs_bit[1] = lane_bit(1, i, delay, l1sync);
            tick();
            if (bus.data_valid) begin
                if (v_count < 4) begin
                    v_idx[v_count]  = i;
                    v_data[v_count] = bus.data;
                end
                v_count++;
            end
            if (bus.sync_err) begin
                if (se_count == 0) se_idx = i;
                se_count++;
            end
            if (i < 80) begin
                trm[i] = bus.termination;
                st[i]  = bus.state_dbg;
            end
        end
        hs_last = bus.hs_active;
        bus.hs_bit = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; set_lp(2'b11); bus.hs_bit = '0;
        tick(); tick();
        tests++; if (bus.state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
        tests++; if (bus.termination !== 1'b0) begin fails++; $display("FAIL reset_term got=%b exp=0", bus.termination); end
        tests++; if (bus.data !== 16'h0) begin fails++; $display("FAIL reset_data got=%h exp=0000", bus.data); end
        tests++; if (bus.data_valid !== 1'b0 || bus.hs_active !== 1'b0 || bus.sync_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags got dv=%b hs=%b se=%b exp=000", bus.data_valid, bus.hs_active, bus.sync_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic a, b, c; int ns; bit ok;
        enter_hs(a, b, c, ns, ok);
        tests++; if (a !== 1'b0 || b !== 1'b0) begin fails++; $display("FAIL basic_term_early got lp01=%b lp00=%b exp=0 0", a, b); end
        tests++; if (c !== 1'b1) begin fails++; $display("FAIL basic_term_rise got=%b exp=1", c); end
        tests++; if (!ok || ns != 16) begin fails++; $display("FAIL basic_settle got ok=%0d cycles=%0d exp=1 16", ok, ns); end
        feed(0, 28, 1'b1);
        tests++; if (v_count != 2) begin fails++; $display("FAIL basic_count got=%0d exp=2", v_count); end
        tests++; if (v_idx[0] != 16 || v_data[0] !== 16'h1212) begin fails++; $display("FAIL basic_word0 got idx=%0d data=%h exp=16 1212", v_idx[0], v_data[0]); end
        tests++; if (v_idx[1] != 24 || v_data[1] !== 16'h3434) begin fails++; $display("FAIL basic_word1 got idx=%0d data=%h exp=24 3434", v_idx[1], v_data[1]); end
        tests++; if (hs_last !== 1'b1) begin fails++; $display("FAIL basic_hs_active got=%b exp=1", hs_last); end
        set_lp(2'b11); tick();
        tests++; if (bus.state_dbg !== 3'd0 || bus.hs_active !== 1'b0) begin fails++; $display("FAIL basic_exit got st=%0d hs=%b exp=0 0", bus.state_dbg, bus.hs_active); end
        tick();
    endtask

    task automatic test_skew();
        logic a, b, c; int ns; bit ok;
        enter_hs(a, b, c, ns, ok);
        tests++; if (!ok) begin fails++; $display("FAIL skew_enter got=0 exp=1"); end
        feed(5, 33, 1'b1);
        tests++; if (v_count != 2) begin fails++; $display("FAIL skew_count got=%0d exp=2", v_count); end
        tests++; if (v_idx[0] != 21 || v_data[0] !== 16'h1212) begin fails++; $display("FAIL skew_word0 got idx=%0d data=%h exp=21 1212", v_idx[0], v_data[0]); end
        tests++; if (v_idx[1] != 29 || v_data[1] !== 16'h3434) begin fails++; $display("FAIL skew_word1 got idx=%0d data=%h exp=29 3434", v_idx[1], v_data[1]); end
        set_lp(2'b11); tick(); tick();
    endtask

    task automatic test_timeout();
        logic a, b, c; int ns; bit ok;
        enter_hs(a, b, c, ns, ok);
        feed(0, 66, 1'b0);
        tests++; if (se_count != 1 || se_idx != 63) begin fails++; $display("FAIL timeout_pulse got n=%0d idx=%0d exp=1 63", se_count, se_idx); end
        tests++; if (trm[62] !== 1'b1 || trm[64] !== 1'b0) begin fails++; $display("FAIL timeout_term got pre=%b post=%b exp=1 0", trm[62], trm[64]); end
        tests++; if (st[64] !== 3'd0) begin fails++; $display("FAIL timeout_state got=%0d exp=0", st[64]); end
        tests++; if (v_count != 0) begin fails++; $display("FAIL timeout_no_data got=%0d exp=0", v_count); end
        set_lp(2'b11); tick();
    endtask

    task automatic test_abort();
        int dv = 0; int tm = 0;
        set_lp(2'b01); tick();
        tests++; if (bus.state_dbg !== 3'd1) begin fails++; $display("FAIL abort_lp01 got=%0d exp=1", bus.state_dbg); end
        set_lp(2'b11); tick();
        tests++; if (bus.state_dbg !== 3'd0) begin fails++; $display("FAIL abort_idle got=%0d exp=0", bus.state_dbg); end
        for (int i = 0; i < 4; i++) begin
            dv += int'(bus.data_valid); tm += int'(bus.termination);
            tick();
        end
        tests++; if (dv != 0 || tm != 0) begin fails++; $display("FAIL abort_quiet got dv=%0d term=%0d exp=0 0", dv, tm); end
    endtask

    task automatic test_mid_recv_exit();
        logic a, b, c; int ns; bit ok; int dv = 0;
        enter_hs(a, b, c, ns, ok);
        feed(0, 20, 1'b1);
        tests++; if (v_count != 1) begin fails++; $display("FAIL midexit_pre got=%0d exp=1", v_count); end
        set_lp(2'b11); tick();
        tests++; if (bus.state_dbg !== 3'd0 || bus.hs_active !== 1'b0) begin fails++; $display("FAIL midexit_idle got st=%0d hs=%b exp=0 0", bus.state_dbg, bus.hs_active); end
        for (int i = 0; i < 10; i++) begin dv += int'(bus.data_valid); tick(); end
        tests++; if (dv != 0) begin fails++; $display("FAIL midexit_extra got=%0d exp=0", dv); end
        enter_hs(a, b, c, ns, ok);
        feed(0, 28, 1'b1);
        tests++; if (v_count != 2 || v_idx[0] != 16 || v_data[0] !== 16'h1212 || v_data[1] !== 16'h3434) begin
            fails++; $display("FAIL midexit_rerun got n=%0d idx=%0d d0=%h d1=%h exp=2 16 1212 3434", v_count, v_idx[0], v_data[0], v_data[1]);
        end
        set_lp(2'b11); tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic a, b, c; int ns; bit ok;
        set_lp(2'b01); tick(); set_lp(2'b00); tick(); tick(); tick(); tick();
        tests++; if (bus.state_dbg !== 3'd3) begin fails++; $display("FAIL rst_settle_pre got=%0d exp=3", bus.state_dbg); end
        reset = 1'b1; tick();
        tests++; if (bus.state_dbg !== 3'd0 || bus.termination !== 1'b0) begin fails++; $display("FAIL rst_settle got st=%0d term=%b exp=0 0", bus.state_dbg, bus.termination); end
        reset = 1'b0; set_lp(2'b11); tick();
        enter_hs(a, b, c, ns, ok);
        feed(0, 20, 1'b1);
        tests++; if (bus.data !== 16'h1212 || bus.hs_active !== 1'b1) begin fails++; $display("FAIL rst_recv_pre got data=%h hs=%b exp=1212 1", bus.data, bus.hs_active); end
        reset = 1'b1; tick();
        tests++; if (bus.state_dbg !== 3'd0 || bus.termination !== 1'b0 || bus.hs_active !== 1'b0) begin
            fails++; $display("FAIL rst_recv_ctl got st=%0d term=%b hs=%b exp=0 0 0", bus.state_dbg, bus.termination, bus.hs_active);
        end
        tests++; if (bus.data !== 16'h0 || bus.data_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
            fails++; $display("FAIL rst_recv_data got data=%h dv=%b se=%b exp=0000 0 0", bus.data, bus.data_valid, bus.sync_err);
        end
        reset = 1'b0; set_lp(2'b11); tick();
    endtask

    initial begin
        reset = 1'b1;
        set_lp(2'b11);
        bus.hs_bit = '0;
        test_reset();
        test_basic();
        test_skew();
        test_timeout();
        test_abort();
        test_mid_recv_exit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
